// File: rtl/pipeline_stall_ctrl.sv
// Hazard/stall sequencer for the 5-stage pipeline: load-use bubbles, multdiv
// start/freeze/release sequencing, and taken-branch flush.
module pipeline_stall_ctrl #(
  parameter int MD_TIMEOUT = 40,
  parameter int CNT_W      = 6    // must satisfy 2**CNT_W > MD_TIMEOUT
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [31:0]      FD_inst,
  input  logic [31:0]      DX_inst,
  input  logic             branch_taken,
  input  logic             md_ready,
  input  logic             md_exception,
  output logic             stall_pc,
  output logic             stall_fd,
  output logic             bubble_dx,
  output logic             hold_dx,
  output logic             flush_fd,
  output logic             ctrl_mult,
  output logic             ctrl_div,
  output logic             md_latch_result,
  output logic             md_error,
  output logic             md_busy,
  output logic [CNT_W-1:0] md_cycles,
  output logic [1:0]       stateDbg
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    MD_RUN  = 2'd1,
    MD_DONE = 2'd2
  } mdStateT;

  localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(MD_TIMEOUT - 1);

  mdStateT          state, nextState;
  logic [CNT_W-1:0] mdCnt, cntNext;
  logic             mdErr, errNext;

  // Decode of the executing (D/X) instruction
  logic [4:0] dxOp, dxAlu, dxRd;
  logic       dxLw, dxMul, dxDiv, dxMd;

  assign dxOp  = DX_inst[31:27];
  assign dxAlu = DX_inst[6:2];
  assign dxRd  = DX_inst[26:22];
  assign dxLw  = (dxOp == 5'b01000);
  assign dxMul = (dxOp == 5'b00000) && (dxAlu == 5'b00110);
  assign dxDiv = (dxOp == 5'b00000) && (dxAlu == 5'b00111);
  assign dxMd  = dxMul | dxDiv;

  // Source fields of the F/D instruction, qualified by its opcode
  logic [4:0] fdOp, fdRs, fdRt, fdRd;
  logic       rsValid, rtValid, rdValid, loadUse;

  assign fdOp = FD_inst[31:27];
  assign fdRd = FD_inst[26:22];
  assign fdRs = FD_inst[21:17];
  assign fdRt = FD_inst[16:12];

  always_comb begin
    rsValid = 1'b0;
    rtValid = 1'b0;
    rdValid = 1'b0;
    case (fdOp)
      5'b00000: begin rsValid = 1'b1; rtValid = 1'b1; end
      5'b00101: rsValid = 1'b1;
      5'b01000: rsValid = 1'b1;
      5'b00111: begin rsValid = 1'b1; rdValid = 1'b1; end
      5'b00010: begin rsValid = 1'b1; rdValid = 1'b1; end
      5'b00110: begin rsValid = 1'b1; rdValid = 1'b1; end
      5'b00100: rdValid = 1'b1;
      default: ;
    endcase
  end

  assign loadUse = dxLw && (dxRd != 5'd0) &&
                   ((rsValid && (fdRs == dxRd)) ||
                    (rtValid && (fdRt == dxRd)) ||
                    (rdValid && (fdRd == dxRd)));

  logic stallPcC, stallFdC, bubbleDxC, holdDxC, flushFdC;
  logic ctrlMultC, ctrlDivC, latchC;

  always_comb begin
    nextState = state;
    cntNext   = mdCnt;
    errNext   = mdErr;
    stallPcC  = 1'b0;
    stallFdC  = 1'b0;
    bubbleDxC = 1'b0;
    holdDxC   = 1'b0;
    flushFdC  = 1'b0;
    ctrlMultC = 1'b0;
    ctrlDivC  = 1'b0;
    latchC    = 1'b0;
    case (state)
      IDLE: begin
        if (branch_taken) begin
          flushFdC  = 1'b1;
          bubbleDxC = 1'b1;
        end else if (dxMd) begin
          ctrlMultC = dxMul;
          ctrlDivC  = dxDiv;
          stallPcC  = 1'b1;
          stallFdC  = 1'b1;
          holdDxC   = 1'b1;
          cntNext   = '0;
          errNext   = 1'b0;
          nextState = MD_RUN;
        end else if (loadUse) begin
          stallPcC  = 1'b1;
          stallFdC  = 1'b1;
          bubbleDxC = 1'b1;
        end
      end
      MD_RUN: begin
        // Branch and load-use are masked: the frozen pipeline cannot act on them
        stallPcC = 1'b1;
        stallFdC = 1'b1;
        holdDxC  = 1'b1;
        if (mdCnt != '1) cntNext = mdCnt + 1'b1;
        if (md_ready) begin
          errNext   = md_exception;
          nextState = MD_DONE;
        end else if (mdCnt == TIMEOUT_LAST) begin
          errNext   = 1'b1;
          nextState = MD_DONE;
        end
      end
      MD_DONE: begin
        latchC    = 1'b1;
        nextState = IDLE;
      end
      default: nextState = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      state <= IDLE;
      mdCnt <= '0;
      mdErr <= 1'b0;
    end else begin
      state <= nextState;
      mdCnt <= cntNext;
      mdErr <= errNext;
    end
  end

  // Every output is held low while reset is asserted
  assign stall_pc        = reset & stallPcC;
  assign stall_fd        = reset & stallFdC;
  assign bubble_dx       = reset & bubbleDxC;
  assign hold_dx         = reset & holdDxC;
  assign flush_fd        = reset & flushFdC;
  assign ctrl_mult       = reset & ctrlMultC;
  assign ctrl_div        = reset & ctrlDivC;
  assign md_latch_result = reset & latchC;
  assign md_error        = reset & mdErr;
  assign md_busy         = reset & (state != IDLE);
  assign md_cycles       = reset ? mdCnt : '0;
  assign stateDbg        = reset ? state : IDLE;

  logic unusedBits;
  assign unusedBits = ^{FD_inst[11:0], DX_inst[21:7], DX_inst[1:0]};

endmodule

// File: tb/tb_pipeline_stall_ctrl.sv
// Directed bench for pipeline_stall_ctrl: load-use, multdiv sequencing,
// exception/timeout, branch priority, back-to-back ops and mid-op reset.
module tb_pipeline_stall_ctrl;

  localparam int CNT_W = 6;

  // Output vector order: {stall_pc, stall_fd, bubble_dx, hold_dx, flush_fd,
  //                       ctrl_mult, ctrl_div, md_latch_result, md_error, md_busy}
  localparam logic [9:0] V_IDLE    = 10'b0000000000;
  localparam logic [9:0] V_LOADUSE = 10'b1110000000;
  localparam logic [9:0] V_BRANCH  = 10'b0010100000;
  localparam logic [9:0] V_MULGO   = 10'b1101010000;
  localparam logic [9:0] V_DIVGO   = 10'b1101001000;
  localparam logic [9:0] V_RUN     = 10'b1101000001;
  localparam logic [9:0] V_DONE    = 10'b0000000101;
  localparam logic [9:0] V_DONEERR = 10'b0000000111;
  localparam logic [9:0] V_ERR     = 10'b0000000010;

  // ---------------- clock / reset ----------------
  logic clock = 1'b0;
  logic reset = 1'b0;
  always #5 clock = ~clock;

  logic [31:0] FD_inst = '0, DX_inst = '0;
  logic branch_taken = 1'b0, md_ready = 1'b0, md_exception = 1'b0;
  logic stall_pc, stall_fd, bubble_dx, hold_dx, flush_fd;
  logic ctrl_mult, ctrl_div, md_latch_result, md_error, md_busy;
  logic [CNT_W-1:0] md_cycles;
  logic [1:0] stateDbg;

  pipeline_stall_ctrl #(.MD_TIMEOUT(40), .CNT_W(CNT_W)) dut (
    .clock(clock), .reset(reset), .FD_inst(FD_inst), .DX_inst(DX_inst),
    .branch_taken(branch_taken), .md_ready(md_ready), .md_exception(md_exception),
    .stall_pc(stall_pc), .stall_fd(stall_fd), .bubble_dx(bubble_dx),
    .hold_dx(hold_dx), .flush_fd(flush_fd), .ctrl_mult(ctrl_mult),
    .ctrl_div(ctrl_div), .md_latch_result(md_latch_result), .md_error(md_error),
    .md_busy(md_busy), .md_cycles(md_cycles), .stateDbg(stateDbg)
  );

  logic [9:0] outVec;
  assign outVec = {stall_pc, stall_fd, bubble_dx, hold_dx, flush_fd,
                   ctrl_mult, ctrl_div, md_latch_result, md_error, md_busy};

  int checks = 0;
  int failures = 0;
  logic [CNT_W-1:0] exp_q[$];

  // ---------------- instruction builders ----------------
  localparam logic [31:0] NOP = 32'd0;

  function automatic logic [31:0] rInst(input logic [4:0] op, input logic [4:0] rd,
                                        input logic [4:0] rs, input logic [4:0] rt,
                                        input logic [4:0] alu);
    return {op, rd, rs, rt, 5'd0, alu, 2'b00};
  endfunction

  function automatic logic [31:0] lwInst(input logic [4:0] rd, input logic [4:0] rs);
    return {5'b01000, rd, rs, 17'd0};
  endfunction

  // ---------------- driver ----------------
  // Inputs change just after the falling edge; outputs are checked 1 time unit later.
  task automatic tick();
    @(negedge clock);
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    DX_inst = rInst(5'd0, 5'd4, 5'd5, 5'd6, 5'b00110);
    branch_taken = 1'b1;
    md_ready = 1'b1;
    for (int i = 0; i < 2; i++) begin
      tick(); #1;
      checks++;
      if (outVec !== V_IDLE || md_cycles !== '0 || stateDbg !== 2'd0) begin
        failures++;
        $display("FAIL reset_forced out=%b cyc=%0d st=%0d required out=%b cyc=0 st=0",
                 outVec, md_cycles, stateDbg, V_IDLE);
      end
    end
    tick();
    reset = 1'b1; DX_inst = NOP; FD_inst = NOP; branch_taken = 1'b0; md_ready = 1'b0;
    #1;
    checks++;
    if (outVec !== V_IDLE || md_cycles !== '0) begin
      failures++;
      $display("FAIL reset_release out=%b cyc=%0d required out=%b cyc=0", outVec, md_cycles, V_IDLE);
    end
  endtask

  task automatic test_load_use();
    logic [31:0] fdVec[6];
    logic [31:0] dxVec[6];
    logic [9:0]  expVec[6];
    // rs match, follow-up nop, rd=r0, rt match, rd-as-source (00111), jump (no sources)
    dxVec[0] = lwInst(5'd3, 5'd1); fdVec[0] = rInst(5'd0, 5'd4, 5'd3, 5'd5, 5'd0);     expVec[0] = V_LOADUSE;
    dxVec[1] = NOP;                fdVec[1] = rInst(5'd0, 5'd4, 5'd3, 5'd5, 5'd0);     expVec[1] = V_IDLE;
    dxVec[2] = lwInst(5'd0, 5'd1); fdVec[2] = rInst(5'd0, 5'd4, 5'd0, 5'd5, 5'd0);     expVec[2] = V_IDLE;
    dxVec[3] = lwInst(5'd3, 5'd1); fdVec[3] = rInst(5'd0, 5'd4, 5'd5, 5'd3, 5'd0);     expVec[3] = V_LOADUSE;
    dxVec[4] = lwInst(5'd3, 5'd1); fdVec[4] = {5'b00111, 5'd3, 5'd9, 17'd0};           expVec[4] = V_LOADUSE;
    dxVec[5] = lwInst(5'd3, 5'd1); fdVec[5] = {5'b00001, 5'd3, 5'd3, 5'd3, 12'd0};     expVec[5] = V_IDLE;
    for (int i = 0; i < 6; i++) begin
      tick();
      DX_inst = dxVec[i]; FD_inst = fdVec[i];
      #1;
      checks++;
      if (outVec !== expVec[i]) begin
        failures++;
        $display("FAIL load_use[%0d] out=%b required=%b", i, outVec, expVec[i]);
      end
    end
    tick(); DX_inst = NOP; FD_inst = NOP;
  endtask

  task automatic test_branch();
    // Branch beats load-use, then beats a pending multiply
    tick();
    DX_inst = lwInst(5'd3, 5'd1); FD_inst = rInst(5'd0, 5'd4, 5'd3, 5'd5, 5'd0); branch_taken = 1'b1;
    #1;
    checks++;
    if (outVec !== V_BRANCH) begin
      failures++;
      $display("FAIL branch_over_loaduse out=%b required=%b", outVec, V_BRANCH);
    end
    tick();
    DX_inst = rInst(5'd0, 5'd4, 5'd5, 5'd6, 5'b00110); FD_inst = NOP;
    #1;
    checks++;
    if (outVec !== V_BRANCH) begin
      failures++;
      $display("FAIL branch_over_mul out=%b required=%b", outVec, V_BRANCH);
    end
    tick();
    DX_inst = NOP; branch_taken = 1'b0;
    #1;
    checks++;
    if (outVec !== V_IDLE || stateDbg !== 2'd0) begin
      failures++;
      $display("FAIL branch_stays_idle out=%b st=%0d required=%b st=0", outVec, stateDbg, V_IDLE);
    end
  endtask

  task automatic test_mul();
    int multPulses = 0;
    tick();
    DX_inst = rInst(5'd0, 5'd4, 5'd5, 5'd6, 5'b00110); FD_inst = NOP;
    #1;
    multPulses += int'(ctrl_mult);
    checks++;
    if (outVec !== V_MULGO) begin
      failures++;
      $display("FAIL mul_start out=%b required=%b", outVec, V_MULGO);
    end
    for (int k = 1; k <= 17; k++) begin
      tick();
      md_ready = (k == 17);
      md_exception = (k == 5);        // ignored without md_ready
      branch_taken = (k == 3);        // ignored while running
      FD_inst = (k == 3) ? rInst(5'd0, 5'd7, 5'd4, 5'd1, 5'd0) : NOP;
      #1;
      multPulses += int'(ctrl_mult);
      checks++;
      if (outVec !== V_RUN || md_cycles !== CNT_W'(k - 1)) begin
        failures++;
        $display("FAIL mul_run[%0d] out=%b cyc=%0d required out=%b cyc=%0d",
                 k, outVec, md_cycles, V_RUN, k - 1);
      end
    end
    tick();
    md_ready = 1'b0; md_exception = 1'b0; branch_taken = 1'b0; FD_inst = NOP;
    #1;
    checks++;
    if (outVec !== V_DONE || md_cycles !== CNT_W'(17) || stateDbg !== 2'd2) begin
      failures++;
      $display("FAIL mul_done out=%b cyc=%0d st=%0d required out=%b cyc=17 st=2",
               outVec, md_cycles, stateDbg, V_DONE);
    end
    tick();
    DX_inst = NOP;
    #1;
    checks++;
    if (outVec !== V_IDLE || md_cycles !== CNT_W'(17) || multPulses != 1) begin
      failures++;
      $display("FAIL mul_after out=%b cyc=%0d pulses=%0d required out=%b cyc=17 pulses=1",
               outVec, md_cycles, multPulses, V_IDLE);
    end
  endtask

  task automatic test_back_to_back();
    int multPulses = 0;
    logic [CNT_W-1:0] expCyc;
    tick();
    DX_inst = rInst(5'd0, 5'd4, 5'd5, 5'd6, 5'b00110);
    for (int op = 0; op < 2; op++) begin
      if (op == 1) tick();            // second mul sits in DX in the IDLE cycle after MD_DONE
      #1;
      multPulses += int'(ctrl_mult);
      checks++;
      if (outVec !== V_MULGO) begin
        failures++;
        $display("FAIL b2b_start[%0d] out=%b required=%b", op, outVec, V_MULGO);
      end
      exp_q.push_back(CNT_W'(op + 2));
      for (int k = 1; k <= op + 2; k++) begin
        tick();
        md_ready = (k == op + 2);
        #1;
        multPulses += int'(ctrl_mult);
        checks++;
        if (outVec !== V_RUN) begin
          failures++;
          $display("FAIL b2b_run[%0d.%0d] out=%b required=%b", op, k, outVec, V_RUN);
        end
      end
      tick();
      md_ready = 1'b0;
      #1;
      expCyc = exp_q.pop_front();
      checks++;
      if (outVec !== V_DONE || md_cycles !== expCyc) begin
        failures++;
        $display("FAIL b2b_done[%0d] out=%b cyc=%0d required out=%b cyc=%0d",
                 op, outVec, md_cycles, V_DONE, expCyc);
      end
    end
    tick();
    DX_inst = NOP;
    #1;
    checks++;
    if (outVec !== V_IDLE || multPulses != 2) begin
      failures++;
      $display("FAIL b2b_pulses out=%b pulses=%0d required out=%b pulses=2", outVec, multPulses, V_IDLE);
    end
  endtask

  task automatic test_div_exception();
    tick();
    DX_inst = rInst(5'd0, 5'd8, 5'd9, 5'd10, 5'b00111);
    #1;
    checks++;
    if (outVec !== V_DIVGO) begin
      failures++;
      $display("FAIL div_start out=%b required=%b", outVec, V_DIVGO);
    end
    for (int k = 1; k <= 3; k++) begin
      tick();
      md_ready = (k == 3); md_exception = (k == 3);
      #1;
      checks++;
      if (outVec !== V_RUN) begin
        failures++;
        $display("FAIL div_run[%0d] out=%b required=%b", k, outVec, V_RUN);
      end
    end
    tick();
    md_ready = 1'b0; md_exception = 1'b0;
    #1;
    checks++;
    if (outVec !== V_DONEERR || md_cycles !== CNT_W'(3)) begin
      failures++;
      $display("FAIL div_exc_done out=%b cyc=%0d required out=%b cyc=3", outVec, md_cycles, V_DONEERR);
    end
    tick();
    DX_inst = NOP;
    #1;
    checks++;
    if (outVec !== V_ERR || stateDbg !== 2'd0) begin
      failures++;
      $display("FAIL div_exc_idle out=%b st=%0d required out=%b st=0", outVec, stateDbg, V_ERR);
    end
  endtask

  task automatic test_timeout();
    tick();
    DX_inst = rInst(5'd0, 5'd8, 5'd9, 5'd10, 5'b00111);
    #1;
    checks++;
    if (outVec !== (V_DIVGO | V_ERR)) begin
      failures++;
      $display("FAIL timeout_start out=%b required=%b", outVec, V_DIVGO | V_ERR);
    end
    for (int k = 1; k <= 40; k++) begin
      tick(); #1;
      checks++;
      if (outVec !== V_RUN || md_cycles !== CNT_W'(k - 1)) begin
        failures++;
        $display("FAIL timeout_run[%0d] out=%b cyc=%0d required out=%b cyc=%0d",
                 k, outVec, md_cycles, V_RUN, k - 1);
      end
    end
    tick(); #1;
    checks++;
    if (outVec !== V_DONEERR || md_cycles !== CNT_W'(40)) begin
      failures++;
      $display("FAIL timeout_done out=%b cyc=%0d required out=%b cyc=40", outVec, md_cycles, V_DONEERR);
    end
    tick();
    DX_inst = NOP;
    #1;
    checks++;
    if (outVec !== V_ERR || stateDbg !== 2'd0) begin
      failures++;
      $display("FAIL timeout_idle out=%b st=%0d required out=%b st=0", outVec, stateDbg, V_ERR);
    end
  endtask

  task automatic test_reset_mid_run();
    tick();
    DX_inst = rInst(5'd0, 5'd4, 5'd5, 5'd6, 5'b00110);
    #1;
    checks++;
    if (outVec !== (V_MULGO | V_ERR)) begin
      failures++;
      $display("FAIL rst_run_start out=%b required=%b", outVec, V_MULGO | V_ERR);
    end
    for (int k = 1; k <= 4; k++) begin
      tick(); #1;
      checks++;
      if (outVec !== V_RUN) begin
        failures++;
        $display("FAIL rst_run[%0d] out=%b required=%b", k, outVec, V_RUN);
      end
    end
    tick();
    reset = 1'b0;
    #1;
    checks++;
    if (outVec !== V_IDLE || md_cycles !== '0) begin
      failures++;
      $display("FAIL rst_run_forced out=%b cyc=%0d required out=%b cyc=0", outVec, md_cycles, V_IDLE);
    end
    tick();
    DX_inst = NOP;
    tick();
    reset = 1'b1; md_ready = 1'b1;
    #1;
    checks++;
    if (outVec !== V_IDLE || md_cycles !== '0 || stateDbg !== 2'd0) begin
      failures++;
      $display("FAIL rst_run_abandon out=%b cyc=%0d st=%0d required out=%b cyc=0 st=0",
               outVec, md_cycles, stateDbg, V_IDLE);
    end
    tick();
    md_ready = 1'b0;
    #1;
    checks++;
    if (outVec !== V_IDLE) begin
      failures++;
      $display("FAIL rst_run_no_latch out=%b required=%b", outVec, V_IDLE);
    end
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    test_reset();
    test_load_use();
    test_branch();
    test_mul();
    test_back_to_back();
    test_div_exception();
    test_timeout();
    test_reset_mid_run();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
    $finish;
  end

endmodule
